// File: rtl/dmem_lsu_ram.sv
// Data RAM with load/store unit (byte/half/word/dword, sign/zero extend); READY 1+WAIT_STATES cycles after accept.
// REQ is dropped while BUSY (WAIT state); DMEM_ALIGN_CHECK_EN turns illegal accesses into MISALIGNED errors.
module dmem_lsu_ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                                           CLK,
    input  logic                                           RESET_N,
    input  logic                                           REQ,
    input  logic                                           WE,
    input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]     ADDR,
    input  logic [1:0]                                     SIZE,
    input  logic                                           UNSIGNED,
    input  logic [DATA_WIDTH-1:0]                          WDATA,
    output logic [DATA_WIDTH-1:0]                          RDATA,
    output logic                                           READY,
    output logic                                           BUSY,
    output logic                                           MISALIGNED
);

    localparam int OFS   = $clog2(DATA_WIDTH/8);
    localparam int NB    = DATA_WIDTH/8;
    localparam int AW    = ADDR_WIDTH + OFS;
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic accept, access;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  we_q, uns_q;
    logic [AW-1:0]         addr_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  a_we, a_uns;
    logic [AW-1:0]         a_addr;
    logic [1:0]            a_size;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic [2:0]            a_off3;

    logic [1:0]            e_size;
    logic [2:0]            e_off;
    logic                  blocked;
    logic [3:0]            nbytes;
    logic [NB-1:0]         mask;
    logic [DATA_WIDTH-1:0] wsh;
    logic [DATA_WIDTH-1:0] word_rd, ld_raw, ld_tmp, ld_val;
    logic signed [DATA_WIDTH-1:0] ld_sext;
    logic [6:0]            sh;
    int                    bits;

    // ---------------- control FSM ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (REQ) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        access    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WS_LOAD;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                    access    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q    <= WE;
            addr_q  <= ADDR;
            size_q  <= SIZE;
            uns_q   <= UNSIGNED;
            wdata_q <= WDATA;
        end
    end

    // With zero wait states the access happens on the accept edge itself, so use the live inputs.
    always_comb begin
        a_we    = (state == WAIT) ? we_q    : WE;
        a_addr  = (state == WAIT) ? addr_q  : ADDR;
        a_size  = (state == WAIT) ? size_q  : SIZE;
        a_uns   = (state == WAIT) ? uns_q   : UNSIGNED;
        a_wdata = (state == WAIT) ? wdata_q : WDATA;
    end

    assign a_idx  = a_addr[AW-1:OFS];
    assign a_off3 = 3'(a_addr[OFS-1:0]);

    // ---------------- alignment handling ----------------
`ifdef DMEM_ALIGN_CHECK_EN
    logic illegal;
    logic mis_q;

    always_comb begin
        illegal = ((a_size == 2'd1) && a_off3[0]) ||
                  ((a_size == 2'd2) && (a_off3[1:0] != 2'd0)) ||
                  ((a_size == 2'd3) && ((DATA_WIDTH == 32) || (a_off3 != 3'd0)));
        e_size  = a_size;
        e_off   = a_off3;
        blocked = illegal;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            mis_q <= 1'b0;
        else if (access)
            mis_q <= blocked;
    end

    assign MISALIGNED = (state == RESP) && mis_q;
`else
    always_comb begin
        e_size  = ((a_size == 2'd3) && (DATA_WIDTH == 32)) ? 2'd2 : a_size;
        // 3'd1<<3 wraps to 0, so a doubleword clears all three offset bits.
        e_off   = a_off3 & ~((3'd1 << e_size) - 3'd1);
        blocked = 1'b0;
    end

    assign MISALIGNED = 1'b0;
`endif

    // ---------------- lane selection ----------------
    assign nbytes = 4'd1 << e_size;

    always_comb begin
        mask = '0;
        for (int b = 0; b < NB; b++)
            mask[b] = (b >= int'(e_off)) && (b < int'(e_off) + int'(nbytes));
    end

    assign wsh = a_wdata << {e_off, 3'b000};

    // Load extension: left-justify the field, then shift back logically or arithmetically.
    always_comb begin
        bits    = 8 << e_size;
        sh      = (bits >= DATA_WIDTH) ? 7'd0 : 7'(DATA_WIDTH - bits);
        word_rd = mem[a_idx];
        ld_raw  = word_rd >> {e_off, 3'b000};
        ld_tmp  = ld_raw << sh;
        ld_sext = $signed(ld_tmp) >>> sh;
        ld_val  = a_uns ? (ld_tmp >> sh) : ld_sext;
    end

    // ---------------- storage and response ----------------
    always_ff @(posedge CLK) begin
        if (RESET_N && access && a_we && !blocked) begin
            for (int b = 0; b < NB; b++)
                if (mask[b])
                    mem[a_idx][b*8 +: 8] <= wsh[b*8 +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N)
            RDATA <= '0;
        else if (access)
            RDATA <= (a_we || blocked) ? '0 : ld_val;
    end

    assign READY = (state == RESP);
    assign BUSY  = (state == WAIT);

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Directed bench for dmem_lsu_ram: 32-bit at 0 and 3 wait states, plus a 64-bit instance.
module tb_dmem_lsu_ram;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET_N;
    logic        req0, req3, req64;
    logic        WE;
    logic [11:0] ADDR;
    logic [1:0]  SIZE;
    logic        UNS;
    logic [63:0] wd;

    logic [31:0] rd0, rd3;
    logic [63:0] rd64;
    logic        rdy0, bsy0, mis0;
    logic        rdy3, bsy3, mis3;
    logic        rdy64, bsy64, mis64;

    int errors = 0;
    int checks = 0;
    int n;
    logic saw_ready;
    logic exp_mis;
    logic [31:0] exp_word;

    dmem_lsu_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(req0), .WE(WE), .ADDR(ADDR), .SIZE(SIZE),
        .UNSIGNED(UNS), .WDATA(wd[31:0]), .RDATA(rd0), .READY(rdy0), .BUSY(bsy0),
        .MISALIGNED(mis0));

    dmem_lsu_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(3)) u3 (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(req3), .WE(WE), .ADDR(ADDR), .SIZE(SIZE),
        .UNSIGNED(UNS), .WDATA(wd[31:0]), .RDATA(rd3), .READY(rdy3), .BUSY(bsy3),
        .MISALIGNED(mis3));

    dmem_lsu_ram #(.ADDR_WIDTH(9), .DATA_WIDTH(64), .WAIT_STATES(0)) u64 (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(req64), .WE(WE), .ADDR(ADDR), .SIZE(SIZE),
        .UNSIGNED(UNS), .WDATA(wd), .RDATA(rd64), .READY(rdy64), .BUSY(bsy64),
        .MISALIGNED(mis64));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_acc(input logic we, input logic [11:0] a, input logic [1:0] sz,
                           input logic u, input logic [63:0] d);
        WE   = we;
        ADDR = a;
        SIZE = sz;
        UNS  = u;
        wd   = d;
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        RESET_N = 1'b0;
        req0 = 1'b0; req3 = 1'b0; req64 = 1'b0;
        set_acc(1'b0, 12'h000, 2'd0, 1'b0, 64'h0);
`ifdef DMEM_ALIGN_CHECK_EN
        exp_mis  = 1'b1;
        exp_word = 32'h80ADBEEF;
`else
        exp_mis  = 1'b0;
        exp_word = 32'h80AD1234;
`endif
        repeat (3) step();

        // reset state
        check("rst_ready0", rdy0, 0);   check("rst_busy0", bsy0, 0);
        check("rst_mis0", mis0, 0);     check("rst_rdata0", rd0, 0);
        check("rst_ready3", rdy3, 0);   check("rst_busy3", bsy3, 0);
        check("rst_mis3", mis3, 0);     check("rst_rdata3", rd3, 0);
        check("rst_ready64", rdy64, 0); check("rst_busy64", bsy64, 0);
        check("rst_mis64", mis64, 0);   check("rst_rdata64", rd64, 0);
        RESET_N = 1'b1;
        step();

        // back-to-back store word / load word, zero wait states
        req0 = 1'b1;
        set_acc(1'b1, 12'h010, 2'd2, 1'b0, 64'hDEADBEEF);
        step();
        check("t1_st_ready", rdy0, 1);
        check("t1_st_rdata", rd0, 0);
        set_acc(1'b0, 12'h010, 2'd2, 1'b0, 64'h0);
        step();
        check("t1_ld_ready", rdy0, 1);
        check("t1_ld_rdata", rd0, 32'hDEADBEEF);
        check("t1_busy", bsy0, 0);
        req0 = 1'b0;
        step();
        check("t1_idle_ready", rdy0, 0);
        check("t1_hold_rdata", rd0, 32'hDEADBEEF);

        // byte store, signed/unsigned byte loads, word and half readback
        req0 = 1'b1;
        set_acc(1'b1, 12'h013, 2'd0, 1'b0, 64'h80);
        step();
        check("t2_stb_ready", rdy0, 1);
        set_acc(1'b0, 12'h013, 2'd0, 1'b0, 64'h0);
        step();
        check("t2_lb_signed", rd0, 32'hFFFFFF80);
        set_acc(1'b0, 12'h013, 2'd0, 1'b1, 64'h0);
        step();
        check("t2_lbu", rd0, 32'h00000080);
        set_acc(1'b0, 12'h010, 2'd2, 1'b0, 64'h0);
        step();
        check("t2_lw", rd0, 32'h80ADBEEF);
        set_acc(1'b0, 12'h012, 2'd1, 1'b0, 64'h0);
        step();
        check("t2_lh_signed", rd0, 32'hFFFF80AD);

        // misaligned half store at 0x011
        set_acc(1'b1, 12'h011, 2'd1, 1'b0, 64'h1234);
        step();
        check("t3_mis_ready", rdy0, 1);
        check("t3_mis_flag", mis0, exp_mis);
        check("t3_mis_rdata", rd0, 0);
        set_acc(1'b0, 12'h010, 2'd2, 1'b0, 64'h0);
        step();
        check("t3_word_after", rd0, exp_word);
        check("t3_mis_clear", mis0, 0);
        req0 = 1'b0;
        step();
        check("t3_idle_mis", mis0, 0);

        // three wait states: busy window and dropped REQ pulse
        req3 = 1'b1;
        set_acc(1'b1, 12'h020, 2'd2, 1'b0, 64'h11223344);
        step();
        req3 = 1'b0;
        check("t4_busy_c1", bsy3, 1);
        check("t4_ready_c1", rdy3, 0);
        step();
        check("t4_busy_c2", bsy3, 1);
        req3 = 1'b1;
        set_acc(1'b0, 12'h010, 2'd2, 1'b0, 64'h0);
        step();
        req3 = 1'b0;
        check("t4_busy_c3", bsy3, 1);
        check("t4_ready_c3", rdy3, 0);
        step();
        check("t4_resp_busy", bsy3, 0);
        check("t4_resp_ready", rdy3, 1);
        check("t4_resp_rdata", rd3, 0);
        step();
        check("t4_after_ready1", rdy3, 0);
        step();
        check("t4_after_ready2", rdy3, 0);
        check("t4_after_busy2", bsy3, 0);

        // load with wait states, latency measured
        req3 = 1'b1;
        set_acc(1'b0, 12'h020, 2'd2, 1'b0, 64'h0);
        step();
        req3 = 1'b0;
        n = 1;
        while (!rdy3 && n < 20) begin
            step();
            n++;
        end
        check("t4_ld_latency", n, 4);
        check("t4_ld_rdata", rd3, 32'h11223344);
        step();

        // reset during WAIT aborts the store
        req3 = 1'b1;
        set_acc(1'b1, 12'h020, 2'd2, 1'b0, 64'h55667788);
        step();
        req3 = 1'b0;
        check("t5_busy", bsy3, 1);
        RESET_N = 1'b0;
        step();
        check("t5_rst_ready", rdy3, 0);
        check("t5_rst_busy", bsy3, 0);
        check("t5_rst_mis", mis3, 0);
        check("t5_rst_rdata", rd3, 0);
        step();
        RESET_N = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rdy3) saw_ready = 1'b1;
        end
        check("t5_no_ready", saw_ready, 0);
        req3 = 1'b1;
        set_acc(1'b0, 12'h020, 2'd2, 1'b0, 64'h0);
        step();
        req3 = 1'b0;
        n = 1;
        while (!rdy3 && n < 20) begin
            step();
            n++;
        end
        check("t5_ld_latency", n, 4);
        check("t5_ld_prestore", rd3, 32'h11223344);
        step();

        // 64-bit data path
        req64 = 1'b1;
        set_acc(1'b1, 12'h008, 2'd3, 1'b0, 64'h0123456789ABCDEF);
        step();
        check("t6_sd_ready", rdy64, 1);
        check("t6_sd_mis", mis64, 0);
        set_acc(1'b0, 12'h00E, 2'd1, 1'b0, 64'h0);
        step();
        check("t6_lh_0E", rd64, 64'h0000000000000123);
        set_acc(1'b0, 12'h008, 2'd0, 1'b0, 64'h0);
        step();
        check("t6_lb_08", rd64, 64'hFFFFFFFFFFFFFFEF);
        set_acc(1'b0, 12'h008, 2'd2, 1'b0, 64'h0);
        step();
        check("t6_lw_08", rd64, 64'hFFFFFFFF89ABCDEF);
        set_acc(1'b0, 12'h00C, 2'd2, 1'b1, 64'h0);
        step();
        check("t6_lwu_0C", rd64, 64'h0000000001234567);
        set_acc(1'b0, 12'h008, 2'd3, 1'b0, 64'h0);
        step();
        check("t6_ld_08", rd64, 64'h0123456789ABCDEF);
        req64 = 1'b0;
        step();
        check("t6_idle_ready", rdy64, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
